// File: rtl/cpu_pkg.sv
// Shared RV32I core definitions: datapath widths, ALU op codes and
// operand-source select encodings used by the decode and execute stages.
package cpu_pkg;

   localparam int CPU_XLEN   = 32;
   localparam int CPU_REG_AW = 5;

   localparam logic [3:0] ALU_ADD  = 4'b0000;
   localparam logic [3:0] ALU_SUB  = 4'b0001;
   localparam logic [3:0] ALU_SLL  = 4'b0010;
   localparam logic [3:0] ALU_SLT  = 4'b0011;
   localparam logic [3:0] ALU_SLTU = 4'b0100;
   localparam logic [3:0] ALU_XOR  = 4'b0101;
   localparam logic [3:0] ALU_SRL  = 4'b0110;
   localparam logic [3:0] ALU_SRA  = 4'b0111;
   localparam logic [3:0] ALU_OR   = 4'b1000;
   localparam logic [3:0] ALU_AND  = 4'b1001;

   typedef enum logic [1:0] {
      SRC_A_RS1   = 2'b00,
      SRC_A_PC    = 2'b01,
      SRC_A_ZERO  = 2'b10,
      SRC_A_ZERO2 = 2'b11
   } src_a_sel_e;

   typedef enum logic [1:0] {
      SRC_B_RS2   = 2'b00,
      SRC_B_IMM   = 2'b01,
      SRC_B_FOUR  = 2'b10,
      SRC_B_ZERO  = 2'b11
   } src_b_sel_e;

endpackage

// File: rtl/id_ex_stage_fwd_mux.sv
// Operand forwarding mux: resolves a register read against the EX/MEM and
// MEM/WB write-back sources, youngest producer first; x0 always reads zero.
module fwd_mux #(
   parameter int XLEN   = 32,
   parameter int REG_AW = 5
) (
   input  logic [REG_AW-1:0] rs_addr_i,
   input  logic [XLEN-1:0]   rs_data_i,
   input  logic [REG_AW-1:0] exmem_rd_addr_i,
   input  logic              exmem_reg_write_i,
   input  logic [XLEN-1:0]   exmem_result_i,
   input  logic [REG_AW-1:0] memwb_rd_addr_i,
   input  logic              memwb_reg_write_i,
   input  logic [XLEN-1:0]   memwb_result_i,
   output logic [XLEN-1:0]   value_o
);

   always_comb begin
      value_o = rs_data_i;
      // A nonzero rs_addr match already implies the producer's rd is nonzero.
      if (rs_addr_i == '0) begin
         value_o = '0;
      end else if (exmem_reg_write_i && (exmem_rd_addr_i == rs_addr_i)) begin
         value_o = exmem_result_i;
      end else if (memwb_reg_write_i && (memwb_rd_addr_i == rs_addr_i)) begin
         value_o = memwb_result_i;
      end
   end

endmodule

// File: rtl/id_ex_stage.sv
// ID/EX pipeline register with load-use hazard detection and operand
// forwarding; presents final ALU operands and op code to the EX stage.
module id_ex_stage
   import cpu_pkg::*;
#(
   parameter int XLEN   = CPU_XLEN,
   parameter int REG_AW = CPU_REG_AW
) (
   input  logic              clk_i,
   input  logic              rst_i,
   input  logic              id_valid_i,
   input  logic [XLEN-1:0]   id_pc_i,
   input  logic [REG_AW-1:0] id_rs1_addr_i,
   input  logic [REG_AW-1:0] id_rs2_addr_i,
   input  logic [XLEN-1:0]   id_rs1_data_i,
   input  logic [XLEN-1:0]   id_rs2_data_i,
   input  logic [XLEN-1:0]   id_imm_i,
   input  logic [REG_AW-1:0] id_rd_addr_i,
   input  logic              id_reg_write_i,
   input  logic              id_is_load_i,
   input  logic [3:0]        id_alu_op_i,
   input  logic [1:0]        id_src_a_sel_i,
   input  logic [1:0]        id_src_b_sel_i,
   input  logic [REG_AW-1:0] exmem_rd_addr_i,
   input  logic              exmem_reg_write_i,
   input  logic [XLEN-1:0]   exmem_result_i,
   input  logic [REG_AW-1:0] memwb_rd_addr_i,
   input  logic              memwb_reg_write_i,
   input  logic [XLEN-1:0]   memwb_result_i,
   input  logic              ex_stall_i,
   input  logic              flush_i,
   output logic              stall_o,
   output logic              ex_valid_o,
   output logic [XLEN-1:0]   operand_a_o,
   output logic [XLEN-1:0]   operand_b_o,
   output logic [3:0]        alu_op_o,
   output logic [XLEN-1:0]   store_data_o,
   output logic [REG_AW-1:0] rd_addr_o,
   output logic              reg_write_o,
   output logic              is_load_o
);

   logic              valid_q,     valid_d;
   logic [XLEN-1:0]   pc_q,        pc_d;
   logic [REG_AW-1:0] rs1_addr_q,  rs1_addr_d;
   logic [REG_AW-1:0] rs2_addr_q,  rs2_addr_d;
   logic [XLEN-1:0]   rs1_data_q,  rs1_data_d;
   logic [XLEN-1:0]   rs2_data_q,  rs2_data_d;
   logic [XLEN-1:0]   imm_q,       imm_d;
   logic [REG_AW-1:0] rd_addr_q,   rd_addr_d;
   logic              reg_write_q, reg_write_d;
   logic              is_load_q,   is_load_d;
   logic [3:0]        alu_op_q,    alu_op_d;
   logic [1:0]        src_a_sel_q, src_a_sel_d;
   logic [1:0]        src_b_sel_q, src_b_sel_d;

   logic              load_use;
   logic [XLEN-1:0]   rs1_fwd, rs2_fwd;
   logic [XLEN-1:0]   op_a, op_b;

   // rs2 is compared unconditionally: stores need it even when src_b is the immediate.
   assign load_use = valid_q && is_load_q && (rd_addr_q != '0) && id_valid_i &&
                     (((rd_addr_q == id_rs1_addr_i) && (id_src_a_sel_i == SRC_A_RS1)) ||
                      (rd_addr_q == id_rs2_addr_i));

   assign stall_o = (ex_stall_i || load_use) && !flush_i;

   always_comb begin
      valid_d     = valid_q;
      pc_d        = pc_q;
      rs1_addr_d  = rs1_addr_q;
      rs2_addr_d  = rs2_addr_q;
      rs1_data_d  = rs1_data_q;
      rs2_data_d  = rs2_data_q;
      imm_d       = imm_q;
      rd_addr_d   = rd_addr_q;
      reg_write_d = reg_write_q;
      is_load_d   = is_load_q;
      alu_op_d    = alu_op_q;
      src_a_sel_d = src_a_sel_q;
      src_b_sel_d = src_b_sel_q;
      if (flush_i || (!ex_stall_i && load_use)) begin
         valid_d     = 1'b0;
         reg_write_d = 1'b0;
         is_load_d   = 1'b0;
         alu_op_d    = ALU_ADD;
      end else if (!ex_stall_i) begin
         valid_d     = id_valid_i;
         pc_d        = id_pc_i;
         rs1_addr_d  = id_rs1_addr_i;
         rs2_addr_d  = id_rs2_addr_i;
         rs1_data_d  = id_rs1_data_i;
         rs2_data_d  = id_rs2_data_i;
         imm_d       = id_imm_i;
         rd_addr_d   = id_rd_addr_i;
         reg_write_d = id_reg_write_i;
         is_load_d   = id_is_load_i;
         alu_op_d    = id_alu_op_i;
         src_a_sel_d = id_src_a_sel_i;
         src_b_sel_d = id_src_b_sel_i;
      end
   end

   always_ff @(posedge clk_i or posedge rst_i) begin
      if (rst_i) begin
         valid_q     <= 1'b0;
         pc_q        <= '0;
         rs1_addr_q  <= '0;
         rs2_addr_q  <= '0;
         rs1_data_q  <= '0;
         rs2_data_q  <= '0;
         imm_q       <= '0;
         rd_addr_q   <= '0;
         reg_write_q <= 1'b0;
         is_load_q   <= 1'b0;
         alu_op_q    <= ALU_ADD;
         src_a_sel_q <= SRC_A_RS1;
         src_b_sel_q <= SRC_B_RS2;
      end else begin
         valid_q     <= valid_d;
         pc_q        <= pc_d;
         rs1_addr_q  <= rs1_addr_d;
         rs2_addr_q  <= rs2_addr_d;
         rs1_data_q  <= rs1_data_d;
         rs2_data_q  <= rs2_data_d;
         imm_q       <= imm_d;
         rd_addr_q   <= rd_addr_d;
         reg_write_q <= reg_write_d;
         is_load_q   <= is_load_d;
         alu_op_q    <= alu_op_d;
         src_a_sel_q <= src_a_sel_d;
         src_b_sel_q <= src_b_sel_d;
      end
   end

   fwd_mux #(.XLEN(XLEN), .REG_AW(REG_AW)) u_fwd_rs1 (
      .rs_addr_i         (rs1_addr_q),
      .rs_data_i         (rs1_data_q),
      .exmem_rd_addr_i   (exmem_rd_addr_i),
      .exmem_reg_write_i (exmem_reg_write_i),
      .exmem_result_i    (exmem_result_i),
      .memwb_rd_addr_i   (memwb_rd_addr_i),
      .memwb_reg_write_i (memwb_reg_write_i),
      .memwb_result_i    (memwb_result_i),
      .value_o           (rs1_fwd)
   );

   fwd_mux #(.XLEN(XLEN), .REG_AW(REG_AW)) u_fwd_rs2 (
      .rs_addr_i         (rs2_addr_q),
      .rs_data_i         (rs2_data_q),
      .exmem_rd_addr_i   (exmem_rd_addr_i),
      .exmem_reg_write_i (exmem_reg_write_i),
      .exmem_result_i    (exmem_result_i),
      .memwb_rd_addr_i   (memwb_rd_addr_i),
      .memwb_reg_write_i (memwb_reg_write_i),
      .memwb_result_i    (memwb_result_i),
      .value_o           (rs2_fwd)
   );

   always_comb begin
      op_a = '0;
      op_b = '0;
      case (src_a_sel_q)
         SRC_A_RS1: op_a = rs1_fwd;
         SRC_A_PC:  op_a = pc_q;
         default:   op_a = '0;
      endcase
      case (src_b_sel_q)
         SRC_B_RS2:  op_b = rs2_fwd;
         SRC_B_IMM:  op_b = imm_q;
         SRC_B_FOUR: op_b = XLEN'(4);
         default:    op_b = '0;
      endcase
   end

   // Anything not holding a live instruction drives a clean ADD 0,0 bubble.
   assign ex_valid_o   = valid_q;
   assign operand_a_o  = valid_q ? op_a : '0;
   assign operand_b_o  = valid_q ? op_b : '0;
   assign alu_op_o     = valid_q ? alu_op_q : ALU_ADD;
   assign store_data_o = valid_q ? rs2_fwd : '0;
   assign rd_addr_o    = rd_addr_q;
   assign reg_write_o  = valid_q && reg_write_q;
   assign is_load_o    = valid_q && is_load_q;

endmodule

// File: tb/tb_id_ex_stage.sv
// Directed bench for id_ex_stage: reset, capture, forwarding priority,
// load-use bubble, downstream stall, flush priority and async reset.
module tb_id_ex_stage;

   logic        clk_i = 1'b0;
   logic        rst_i;
   logic        id_valid_i;
   logic [31:0] id_pc_i;
   logic [4:0]  id_rs1_addr_i, id_rs2_addr_i;
   logic [31:0] id_rs1_data_i, id_rs2_data_i;
   logic [31:0] id_imm_i;
   logic [4:0]  id_rd_addr_i;
   logic        id_reg_write_i, id_is_load_i;
   logic [3:0]  id_alu_op_i;
   logic [1:0]  id_src_a_sel_i, id_src_b_sel_i;
   logic [4:0]  exmem_rd_addr_i, memwb_rd_addr_i;
   logic        exmem_reg_write_i, memwb_reg_write_i;
   logic [31:0] exmem_result_i, memwb_result_i;
   logic        ex_stall_i, flush_i;
   logic        stall_o, ex_valid_o, reg_write_o, is_load_o;
   logic [31:0] operand_a_o, operand_b_o, store_data_o;
   logic [3:0]  alu_op_o;
   logic [4:0]  rd_addr_o;

   int total = 0;
   int bad   = 0;

   id_ex_stage dut (
      .clk_i             (clk_i),
      .rst_i             (rst_i),
      .id_valid_i        (id_valid_i),
      .id_pc_i           (id_pc_i),
      .id_rs1_addr_i     (id_rs1_addr_i),
      .id_rs2_addr_i     (id_rs2_addr_i),
      .id_rs1_data_i     (id_rs1_data_i),
      .id_rs2_data_i     (id_rs2_data_i),
      .id_imm_i          (id_imm_i),
      .id_rd_addr_i      (id_rd_addr_i),
      .id_reg_write_i    (id_reg_write_i),
      .id_is_load_i      (id_is_load_i),
      .id_alu_op_i       (id_alu_op_i),
      .id_src_a_sel_i    (id_src_a_sel_i),
      .id_src_b_sel_i    (id_src_b_sel_i),
      .exmem_rd_addr_i   (exmem_rd_addr_i),
      .exmem_reg_write_i (exmem_reg_write_i),
      .exmem_result_i    (exmem_result_i),
      .memwb_rd_addr_i   (memwb_rd_addr_i),
      .memwb_reg_write_i (memwb_reg_write_i),
      .memwb_result_i    (memwb_result_i),
      .ex_stall_i        (ex_stall_i),
      .flush_i           (flush_i),
      .stall_o           (stall_o),
      .ex_valid_o        (ex_valid_o),
      .operand_a_o       (operand_a_o),
      .operand_b_o       (operand_b_o),
      .alu_op_o          (alu_op_o),
      .store_data_o      (store_data_o),
      .rd_addr_o         (rd_addr_o),
      .reg_write_o       (reg_write_o),
      .is_load_o         (is_load_o)
   );

   always #5 clk_i = ~clk_i;

   task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      total++;
      assert (obs === exp) else begin
         bad++;
         $error("FAIL %s observed=0x%0h expected=0x%0h", tag, obs, exp);
      end
   endtask

   task automatic step();
      @(posedge clk_i);
      #1;
   endtask

   task automatic set_instr(input logic [31:0] pc, input logic [4:0] rs1, input logic [31:0] d1,
                            input logic [4:0] rs2, input logic [31:0] d2, input logic [31:0] imm,
                            input logic [4:0] rd, input logic rw, input logic ld,
                            input logic [3:0] op, input logic [1:0] sa, input logic [1:0] sb);
      id_valid_i     = 1'b1;
      id_pc_i        = pc;
      id_rs1_addr_i  = rs1;
      id_rs1_data_i  = d1;
      id_rs2_addr_i  = rs2;
      id_rs2_data_i  = d2;
      id_imm_i       = imm;
      id_rd_addr_i   = rd;
      id_reg_write_i = rw;
      id_is_load_i   = ld;
      id_alu_op_i    = op;
      id_src_a_sel_i = sa;
      id_src_b_sel_i = sb;
   endtask

   initial begin
      rst_i = 1'b1;
      id_valid_i = 0; id_pc_i = 0; id_rs1_addr_i = 0; id_rs2_addr_i = 0;
      id_rs1_data_i = 0; id_rs2_data_i = 0; id_imm_i = 0; id_rd_addr_i = 0;
      id_reg_write_i = 0; id_is_load_i = 0; id_alu_op_i = 0;
      id_src_a_sel_i = 0; id_src_b_sel_i = 0;
      exmem_rd_addr_i = 0; exmem_reg_write_i = 0; exmem_result_i = 0;
      memwb_rd_addr_i = 0; memwb_reg_write_i = 0; memwb_result_i = 0;
      ex_stall_i = 0; flush_i = 0;
      step();
      step();
      rst_i = 1'b0;

      // Reset state
      chk("rst_valid", 32'(ex_valid_o), 32'd0);
      chk("rst_alu_op", 32'(alu_op_o), 32'd0);
      chk("rst_stall", 32'(stall_o), 32'd0);
      chk("rst_op_a", operand_a_o, 32'd0);
      chk("rst_op_b", operand_b_o, 32'd0);
      chk("rst_reg_write", 32'(reg_write_o), 32'd0);

      // ADDI x5, x1, 7 with x1 = 10
      set_instr(32'h0, 5'd1, 32'd10, 5'd0, 32'd0, 32'd7, 5'd5, 1'b1, 1'b0, 4'b0000, 2'b00, 2'b01);
      step();
      chk("addi_valid", 32'(ex_valid_o), 32'd1);
      chk("addi_op_a", operand_a_o, 32'd10);
      chk("addi_op_b", operand_b_o, 32'd7);
      chk("addi_alu_op", 32'(alu_op_o), 32'd0);
      chk("addi_rd", 32'(rd_addr_o), 32'd5);
      chk("addi_reg_write", 32'(reg_write_o), 32'd1);

      // Forwarding priority on rs1 = x3, rs2 = x3 (store data path), src_b = constant 4
      set_instr(32'h4, 5'd3, 32'h1111, 5'd3, 32'h2222, 32'd0, 5'd7, 1'b1, 1'b0, 4'b0001, 2'b00, 2'b10);
      exmem_rd_addr_i = 5'd3; exmem_reg_write_i = 1'b1; exmem_result_i = 32'hAAAA;
      memwb_rd_addr_i = 5'd3; memwb_reg_write_i = 1'b1; memwb_result_i = 32'h5555;
      step();
      id_valid_i = 1'b0;
      chk("fwd_exmem_a", operand_a_o, 32'hAAAA);
      chk("fwd_exmem_store", store_data_o, 32'hAAAA);
      chk("fwd_const4_b", operand_b_o, 32'd4);
      chk("fwd_alu_op", 32'(alu_op_o), 32'd1);
      exmem_reg_write_i = 1'b0;
      #1;
      chk("fwd_memwb_a", operand_a_o, 32'h5555);
      memwb_reg_write_i = 1'b0;
      #1;
      chk("fwd_none_a", operand_a_o, 32'h1111);
      chk("fwd_none_store", store_data_o, 32'h2222);

      // x0 read with rd=0 sources writing: always zero
      set_instr(32'h8, 5'd0, 32'hDEAD, 5'd0, 32'hBEEF, 32'd0, 5'd8, 1'b1, 1'b0, 4'b1000, 2'b00, 2'b00);
      exmem_rd_addr_i = 5'd0; exmem_reg_write_i = 1'b1; exmem_result_i = 32'h1234;
      memwb_rd_addr_i = 5'd0; memwb_reg_write_i = 1'b1; memwb_result_i = 32'h5678;
      step();
      chk("x0_op_a", operand_a_o, 32'd0);
      chk("x0_op_b", operand_b_o, 32'd0);
      exmem_reg_write_i = 1'b0; memwb_reg_write_i = 1'b0;

      // PC / immediate selection
      set_instr(32'h100, 5'd1, 32'h99, 5'd2, 32'h77, 32'h3000, 5'd9, 1'b1, 1'b0, 4'b0000, 2'b01, 2'b01);
      step();
      chk("pc_op_a", operand_a_o, 32'h100);
      chk("imm_op_b", operand_b_o, 32'h3000);

      // Load-use: LW x4, 8(x2) then ADD x6, x4, x2
      set_instr(32'h104, 5'd2, 32'h40, 5'd0, 32'd0, 32'd8, 5'd4, 1'b1, 1'b1, 4'b0000, 2'b00, 2'b01);
      step();
      chk("lw_is_load", 32'(is_load_o), 32'd1);
      set_instr(32'h108, 5'd4, 32'h999, 5'd2, 32'h20, 32'd0, 5'd6, 1'b1, 1'b0, 4'b0000, 2'b00, 2'b00);
      #1;
      chk("lu_stall", 32'(stall_o), 32'd1);
      step();
      chk("lu_bubble_valid", 32'(ex_valid_o), 32'd0);
      chk("lu_bubble_rw", 32'(reg_write_o), 32'd0);
      chk("lu_bubble_alu", 32'(alu_op_o), 32'd0);
      chk("lu_bubble_a", operand_a_o, 32'd0);
      chk("lu_stall_released", 32'(stall_o), 32'd0);
      exmem_rd_addr_i = 5'd4; exmem_reg_write_i = 1'b1; exmem_result_i = 32'h77;
      step();
      chk("lu_add_valid", 32'(ex_valid_o), 32'd1);
      chk("lu_add_a_fwd", operand_a_o, 32'h77);
      chk("lu_add_b", operand_b_o, 32'h20);
      chk("lu_add_rd", 32'(rd_addr_o), 32'd6);

      // Downstream stall for 3 cycles with a different decode instruction waiting
      set_instr(32'h10C, 5'd1, 32'h5, 5'd1, 32'h5, 32'd0, 5'd9, 1'b1, 1'b0, 4'b0001, 2'b00, 2'b00);
      ex_stall_i = 1'b1;
      #1;
      chk("exs_stall_o", 32'(stall_o), 32'd1);
      for (int i = 0; i < 3; i++) begin
         step();
         chk("exs_hold_rd", 32'(rd_addr_o), 32'd6);
         chk("exs_hold_alu", 32'(alu_op_o), 32'd0);
         chk("exs_hold_valid", 32'(ex_valid_o), 32'd1);
         chk("exs_stall_held", 32'(stall_o), 32'd1);
      end
      exmem_result_i = 32'h88;
      #1;
      chk("exs_fwd_live", operand_a_o, 32'h88);
      ex_stall_i = 1'b0;
      exmem_reg_write_i = 1'b0;
      step();
      chk("exs_release_rd", 32'(rd_addr_o), 32'd9);
      chk("exs_release_alu", 32'(alu_op_o), 32'd1);
      chk("exs_release_a", operand_a_o, 32'h5);

      // Flush with stall and load-use hazard pending in the same cycle
      set_instr(32'h110, 5'd2, 32'h40, 5'd0, 32'd0, 32'd0, 5'd4, 1'b1, 1'b1, 4'b0000, 2'b00, 2'b01);
      step();
      set_instr(32'h114, 5'd4, 32'h1, 5'd4, 32'h1, 32'd0, 5'd6, 1'b1, 1'b0, 4'b0000, 2'b00, 2'b00);
      ex_stall_i = 1'b1;
      flush_i    = 1'b1;
      #1;
      chk("flush_stall_o", 32'(stall_o), 32'd0);
      step();
      chk("flush_valid", 32'(ex_valid_o), 32'd0);
      chk("flush_rw", 32'(reg_write_o), 32'd0);
      ex_stall_i = 1'b0;
      flush_i    = 1'b0;

      // Asynchronous reset in mid-cycle with a live instruction in the stage
      set_instr(32'h200, 5'd1, 32'h33, 5'd2, 32'h44, 32'd0, 5'd10, 1'b1, 1'b0, 4'b1001, 2'b00, 2'b00);
      step();
      chk("prerst_valid", 32'(ex_valid_o), 32'd1);
      chk("prerst_alu", 32'(alu_op_o), 32'd9);
      #2;
      rst_i = 1'b1;
      #1;
      chk("arst_valid", 32'(ex_valid_o), 32'd0);
      chk("arst_alu", 32'(alu_op_o), 32'd0);
      chk("arst_op_a", operand_a_o, 32'd0);
      chk("arst_op_b", operand_b_o, 32'd0);
      chk("arst_rw", 32'(reg_write_o), 32'd0);
      step();
      rst_i = 1'b0;
      id_valid_i = 1'b0;
      step();
      chk("post_rst_valid", 32'(ex_valid_o), 32'd0);

      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end

endmodule
